// File: rtl/if_id_fifo_pkg.sv
// -----------------------------------------------------------------------------
// if_id_fifo_pkg
// Shared constants for the fetch/decode boundary.
//   `INST_WIDTH     : instruction width (32)
//   `SYS_ADDR_SPACE : program counter width (32)
//   `NOP_INST       : canonical bubble instruction, addi x0,x0,0 (32'h0000_0013).
//                     Decode uses the same value for its own bubbles.
// The package carries the typed defaults used by if_id_fifo.
// Optional feature macro used by this slice: IF_ID_PERF_CNT_EN.
// -----------------------------------------------------------------------------
`ifndef IF_ID_DEFINES_SVH
`define IF_ID_DEFINES_SVH
`define INST_WIDTH 32
`define SYS_ADDR_SPACE 32
`define NOP_INST 32'h0000_0013
`endif

package if_id_fifo_pkg;

    localparam int unsigned DEFAULT_DEPTH = 2;
    localparam logic [31:0] NOP_INST_VAL  = `NOP_INST;

endpackage

// File: rtl/if_id_fifo_sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
// 32-bit event counter that sticks at 32'hFFFF_FFFF instead of wrapping.
// Only built when IF_ID_PERF_CNT_EN is defined.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val into the counter (has priority over inc)
//   load_val : value to load
//   inc      : count one event this cycle
//   count    : current count
// -----------------------------------------------------------------------------
`ifdef IF_ID_PERF_CNT_EN
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule
`endif

// File: rtl/if_id_fifo.sv
// -----------------------------------------------------------------------------
// if_id_fifo
// Circular buffer between instruction fetch and decode. Each accepted
// {pc, inst} pair is stored and the oldest one is presented to decode.
// Fetch is held off with stall_o while the buffer is full; a flush discards
// every buffered entry on a redirect.
// Optional feature: define IF_ID_PERF_CNT_EN to add the stall/bubble counters.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   valid_i      : fetch presents a valid instruction
//   inst_i/pc_i  : fetched instruction and its PC
//   stall_o      : buffer full, fetch must hold its PC
//   flush_i      : discard all entries (wins over push and pop)
//   ready_i      : decode accepts the head entry
//   valid_o      : head entry valid
//   inst_o/pc_o  : head entry (NOP / 0 while empty)
//   count_o      : occupancy
//   stall_cnt_o  : (IF_ID_PERF_CNT_EN) cycles with stall_o and valid_i high
//   bubble_cnt_o : (IF_ID_PERF_CNT_EN) cycles with nothing to decode, no flush
// -----------------------------------------------------------------------------
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int unsigned       DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned       INST_W   = `INST_WIDTH,
    parameter int unsigned       ADDR_W   = `SYS_ADDR_SPACE,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_VAL)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          pc_i,
    output logic                       stall_o,
    input  logic                       flush_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                bubble_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // full/empty come straight from the count register, so stall_o has no
    // combinational path from ready_i or valid_i. A pop while full does not
    // admit the same-cycle fetch; the refill happens the following cycle.
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign push  = valid_i & ~full;
    assign pop   = ready_i & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; entries are only meaningful below count_reg.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            pc_mem[wr_ptr_reg]   <= pc_i;
            inst_mem[wr_ptr_reg] <= inst_i;
        end
    end

    assign stall_o = full;
    assign valid_o = ~empty;
    assign inst_o  = empty ? NOP_INST : inst_mem[rd_ptr_reg];
    assign pc_o    = empty ? '0 : pc_mem[rd_ptr_reg];
    assign count_o = count_reg;

`ifdef IF_ID_PERF_CNT_EN
    sat_counter32 u_stall_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (1'b0),
        .load_val (32'h0),
        .inc      (full & valid_i),
        .count    (stall_cnt_o)
    );

    sat_counter32 u_bubble_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (1'b0),
        .load_val (32'h0),
        .inc      (empty & ~flush_i),
        .count    (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// -----------------------------------------------------------------------------
// tb_if_id_fifo
// Self-checking bench for if_id_fifo (DEPTH = 2). A table of per-cycle
// vectors checks occupancy/flags/head after each edge; a scoreboard queue
// checks every entry decode consumes against what fetch pushed.
// -----------------------------------------------------------------------------
module tb_if_id_fifo;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [31:0]   inst_i = '0;
    logic [31:0]   pc_i = '0;
    logic          stall_o;
    logic          flush_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [31:0]   inst_o;
    logic [31:0]   pc_o;
    logic [CW-1:0] count_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0]   stall_cnt_o;
    logic [31:0]   bubble_cnt_o;
    logic          sat_ld = 1'b0;
    logic [31:0]   sat_lv = '0;
    logic          sat_inc = 1'b0;
    logic [31:0]   sat_q;
`endif

    if_id_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .inst_i  (inst_i),
        .pc_i    (pc_i),
        .stall_o (stall_o),
        .flush_i (flush_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .inst_o  (inst_o),
        .pc_o    (pc_o),
        .count_o (count_o)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

`ifdef IF_ID_PERF_CNT_EN
    sat_counter32 u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sat_ld),
        .load_val (sat_lv),
        .inc      (sat_inc),
        .count    (sat_q)
    );
`endif

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t sb[$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        r;
        logic        f;
        logic        ev;
        logic        es;
        int          ec;
        logic [31:0] epc;
    } vec_t;
    vec_t vt[15];

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'h0050_0093 + (pc << 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample/score at negedge, return at posedge+1.
    task automatic step(input logic v, input logic [31:0] pc, input logic r, input logic f);
        valid_i = v;
        pc_i    = pc;
        inst_i  = mk_inst(pc);
        ready_i = r;
        flush_i = f;
        @(negedge clk);
        check("sb_count", 32'(count_o), 32'(sb.size()));
        check("sb_valid", 32'(valid_o), 32'(sb.size() != 0));
        check("sb_stall", 32'(stall_o), 32'(sb.size() == DEPTH));
        if (f) begin
            sb.delete();
        end else begin
            if (r && valid_o) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry", pc_o);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    check("head_pc", pc_o, e.pc);
                    check("head_inst", inst_o, e.inst);
                    $display("[TB] pop  pc=%h inst=%h", pc_o, inst_o);
                end
            end
            if (v && !stall_o) begin
                sb.push_back('{pc, mk_inst(pc)});
                $display("[TB] push pc=%h", pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        v     pc            r     f     ev    es    ec  epc
        vt[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 32'h00};
        vt[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'h00};
        vt[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'h00};
        vt[3]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h04};
        vt[4]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h08};
        vt[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h00};
        vt[6]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h10};
        vt[7]  = '{1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h14};
        vt[8]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h18};
        vt[9]  = '{1'b1, 32'h1c, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h1c};
        vt[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'h1c};
        vt[11] = '{1'b1, 32'h24, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h00};
        vt[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h00};
        vt[13] = '{1'b1, 32'h28, 1'b0, 1'b0, 1'b1, 1'b0, 1, 32'h28};
        vt[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h00};

        // Reset held with fetch active: nothing may be captured.
        rst_n   = 1'b0;
        valid_i = 1'b1;
        pc_i    = 32'h0;
        inst_i  = 32'h0050_0093;
        #12;
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_inst", inst_o, NOP);
        check("rst_pc", pc_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_count", 32'(count_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: fill/backpressure, streaming, flush priority.
        for (int i = 0; i < 15; i++) begin
            step(vt[i].v, vt[i].pc, vt[i].r, vt[i].f);
            check($sformatf("row%0d_valid", i), 32'(valid_o), 32'(vt[i].ev));
            check($sformatf("row%0d_stall", i), 32'(stall_o), 32'(vt[i].es));
            check($sformatf("row%0d_count", i), 32'(count_o), 32'(vt[i].ec));
            check($sformatf("row%0d_pc", i), pc_o, vt[i].ev ? vt[i].epc : 32'h0);
            check($sformatf("row%0d_inst", i), inst_o, vt[i].ev ? mk_inst(vt[i].epc) : NOP);
        end

        // Wrap-around: fetch re-presents a stalled PC; order checked by scoreboard.
        begin
            logic [31:0] nxt;
            nxt = 32'h100;
            for (int i = 0; i < 10; i++) begin
                logic acc;
                acc = !stall_o;
                step(1'b1, nxt, (i % 2) == 0, 1'b0);
                if (acc) nxt += 32'd4;
            end
            for (int k = 0; k < 8 && sb.size() > 0; k++) begin
                step(1'b0, 32'h0, 1'b1, 1'b0);
            end
            check("drain_left", 32'(sb.size()), 32'h0);
            check("drain_valid", 32'(valid_o), 32'h0);
        end

        // Reset mid-operation clears contents without a clock edge.
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0);
        valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count_o), 32'h0);
        check("arst_valid", 32'(valid_o), 32'h0);
        check("arst_stall", 32'(stall_o), 32'h0);
        check("arst_inst", inst_o, NOP);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef IF_ID_PERF_CNT_EN
        check("perf_rst_stall", stall_cnt_o, 32'd0);
        check("perf_rst_bubble", bubble_cnt_o, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        check("perf_bubble3", bubble_cnt_o, 32'd3);
        step(1'b1, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h308, 1'b0, 1'b0);
        check("perf_stall5", stall_cnt_o, 32'd5);
        check("perf_bubble4", bubble_cnt_o, 32'd4);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("perf_flush_bubble", bubble_cnt_o, 32'd4);
        check("perf_flush_stall", stall_cnt_o, 32'd5);

        sat_ld = 1'b1;
        sat_lv = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        sat_ld  = 1'b0;
        sat_inc = 1'b1;
        @(posedge clk);
        #1;
        check("sat_reach", sat_q, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", sat_q, 32'hFFFF_FFFF);
        sat_inc = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
